// File: rtl/score_arbiter_pkg.sv
// Shared types for the two-player score path: BCD digit, packed two-digit
// score, player index and the controller state encoding.
package score_pkg;

  localparam int NUM_PLAYERS = 2;
  localparam int PID_W       = 1;

  typedef logic [3:0]       bcd_t;
  typedef logic [PID_W-1:0] pid_t;

  typedef struct packed {
    bcd_t tens;
    bcd_t ones;
  } score_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    INC  = 2'd2,
    DONE = 2'd3
  } state_t;

endpackage

// File: rtl/bcd2_inc.sv
// Two-digit BCD +1, saturating at 99. Purely combinational; the top shares a
// single instance between both players through a mux on the granted player.
module bcd2_inc
  import score_pkg::*;
(
  input  score_t d,
  output score_t q
);

  // Ones carry into tens; 99 stays put.
  always_comb begin
    q = d;
    if (d.tens == 4'd9 && d.ones == 4'd9) begin
      q = d;
    end else if (d.ones == 4'd9) begin
      q.ones = 4'd0;
      q.tens = d.tens + 4'd1;
    end else begin
      q.ones = d.ones + 4'd1;
    end
  end

endmodule

// File: rtl/score_arbiter.sv
// Two-player score controller: edge-detects both buttons, queues presses as
// pending bits, round-robin arbitrates one shared BCD incrementer, and stops
// scoring once a player reaches the win score.
module score_arbiter
  import score_pkg::*;
#(
  parameter logic [3:0] WIN_TENS = 4'd2,
  parameter logic [3:0] WIN_ONES = 4'd0
) (
  input  logic                   clk,
  input  logic                   resetn,
  input  logic                   start,
  input  logic                   clear,
  input  logic [NUM_PLAYERS-1:0] press,
  output logic [3:0]             p0_ones,
  output logic [3:0]             p0_tens,
  output logic [3:0]             p1_ones,
  output logic [3:0]             p1_tens,
  output logic [NUM_PLAYERS-1:0] grant,
  output logic [NUM_PLAYERS-1:0] winner,
  output logic                   game_over
);

  localparam score_t WIN_SCORE = '{tens: WIN_TENS, ones: WIN_ONES};
  localparam logic [NUM_PLAYERS-1:0] ONE = {{(NUM_PLAYERS-1){1'b0}}, 1'b1};

  state_t                      state_q, state_d;
  logic [NUM_PLAYERS-1:0]      press_q, rise;
  logic [NUM_PLAYERS-1:0]      pend_q, pend_d;
  pid_t                        gnt_q, gnt_d, rr_q;
  score_t [NUM_PLAYERS-1:0]    score_q;
  logic [NUM_PLAYERS-1:0]      winner_q;
  score_t                      inc_in, inc_out;
  logic                        hit_win, do_grant;

  assign rise     = press & ~press_q;
  assign do_grant = (state_q == RUN) && (|pend_q);

  // Shared incrementer, fed by whichever player holds the grant.
  assign inc_in  = score_q[gnt_q];
  assign hit_win = (inc_out == WIN_SCORE);

  bcd2_inc u_inc (
    .d (inc_in),
    .q (inc_out)
  );

  // Arbitration: a lone requester wins; on a tie the player other than rr wins.
  always_comb begin
    if (&pend_q) gnt_d = ~rr_q;
    else         gnt_d = pid_t'(pend_q[1]);
  end

  // Pending queue: grant clears, a rise sets (set wins), a win discards all.
  always_comb begin
    pend_d = pend_q;
    if (clear) begin
      pend_d = '0;
    end else if (state_q == INC && hit_win) begin
      pend_d = '0;
    end else begin
      if (do_grant) pend_d[gnt_d] = 1'b0;
      if (state_q == RUN || state_q == INC) pend_d = pend_d | rise;
    end
  end

  // Controller next state; clear overrides everything, including start.
  always_comb begin
    state_d = state_q;
    if (clear) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:    if (start) state_d = RUN;
        RUN:     if (|pend_q) state_d = INC;
        INC:     state_d = hit_win ? DONE : RUN;
        DONE:    state_d = DONE;
        default: state_d = IDLE;
      endcase
    end
  end

  // Edge-detect history runs every cycle regardless of state.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) press_q <= '0;
    else         press_q <= press;
  end

  // FSM, pending and arbitration registers. rr resets to player 1 so player 0
  // takes the first tie.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
      pend_q  <= '0;
      gnt_q   <= '0;
      rr_q    <= pid_t'(1);
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      if (do_grant && !clear) begin
        gnt_q <= gnt_d;
        rr_q  <= gnt_d;
      end
    end
  end

  // Scores and winner: the granted player's score commits at the INC exit edge.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      score_q  <= '0;
      winner_q <= '0;
    end else if (clear) begin
      score_q  <= '0;
      winner_q <= '0;
    end else if (state_q == INC) begin
      score_q[gnt_q] <= inc_out;
      if (hit_win) winner_q <= ONE << gnt_q;
    end
  end

  assign grant     = (state_q == INC) ? (ONE << gnt_q) : '0;
  assign winner    = winner_q;
  assign game_over = (state_q == DONE);

  assign p0_ones = score_q[0].ones;
  assign p0_tens = score_q[0].tens;
  assign p1_ones = score_q[1].ones;
  assign p1_tens = score_q[1].tens;

endmodule

// File: tb/tb_score_arbiter.sv
// Bench for score_arbiter: vector table, directed corner sequences and a
// randomized run, all compared against an integer-score reference model.
module tb_score_arbiter;

  localparam int WIN = 20;
  localparam int P_IDLE = 0, P_RUN = 1, P_SERVE = 2, P_DONE = 3;

  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic       start = 1'b0;
  logic       clear = 1'b0;
  logic [1:0] press = 2'b00;
  logic [3:0] p0_ones, p0_tens, p1_ones, p1_tens;
  logic [1:0] grant, winner;
  logic       game_over;

  score_arbiter dut (
    .clk(clk), .resetn(resetn), .start(start), .clear(clear), .press(press),
    .p0_ones(p0_ones), .p0_tens(p0_tens), .p1_ones(p1_ones), .p1_tens(p1_tens),
    .grant(grant), .winner(winner), .game_over(game_over)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference model: scores as plain integers, a phase, and a request set.
  int       m_score[2];
  int       m_phase;
  int       m_g;
  int       m_rr;
  int       m_win;
  bit [1:0] m_pend;
  bit [1:0] m_prev;

  task automatic check(string nm, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic int to_bcd(int s);
    return (s / 10) * 16 + (s % 10);
  endfunction

  task automatic model_reset();
    m_score[0] = 0; m_score[1] = 0;
    m_phase = P_IDLE; m_g = 0; m_rr = 1; m_win = -1;
    m_pend = 2'b00; m_prev = 2'b00;
  endtask

  task automatic model_step(bit st, bit cl, logic [1:0] pr);
    bit [1:0] r;
    int s;
    r = pr & ~m_prev;
    m_prev = pr;
    if (cl) begin
      m_phase = P_IDLE; m_score[0] = 0; m_score[1] = 0;
      m_pend = 2'b00; m_win = -1;
    end else begin
      case (m_phase)
        P_IDLE: if (st) m_phase = P_RUN;
        P_RUN: begin
          if (m_pend != 2'b00) begin
            if (m_pend == 2'b11) m_g = 1 - m_rr;
            else                 m_g = m_pend[0] ? 0 : 1;
            m_rr = m_g;
            m_pend[m_g] = 1'b0;
            m_phase = P_SERVE;
          end
          m_pend = m_pend | r;
        end
        P_SERVE: begin
          s = m_score[m_g] + 1;
          if (s > 99) s = 99;
          m_score[m_g] = s;
          if (s == WIN) begin
            m_phase = P_DONE; m_win = m_g; m_pend = 2'b00;
          end else begin
            m_phase = P_RUN; m_pend = m_pend | r;
          end
        end
        default: ;
      endcase
    end
  endtask

  task automatic cmp_model(string tag);
    check({tag, "_p0"}, {p0_tens, p0_ones}, to_bcd(m_score[0]));
    check({tag, "_p1"}, {p1_tens, p1_ones}, to_bcd(m_score[1]));
    check({tag, "_grant"}, grant, (m_phase == P_SERVE) ? (1 << m_g) : 0);
    check({tag, "_winner"}, winner, (m_win < 0) ? 0 : (1 << m_win));
    check({tag, "_game_over"}, game_over, (m_phase == P_DONE) ? 1 : 0);
  endtask

  // One clock: drive inputs, advance model, sample 1 time unit after the edge.
  task automatic cyc(bit st, bit cl, logic [1:0] pr);
    start = st; clear = cl; press = pr;
    model_step(st, cl, pr);
    @(posedge clk);
    #1;
    cmp_model("model");
  endtask

  task automatic pulse(logic [1:0] pr);
    cyc(1'b1, 1'b0, pr);
    cyc(1'b1, 1'b0, 2'b00);
    cyc(1'b1, 1'b0, 2'b00);
  endtask

  task automatic do_reset(string tag);
    start = 1'b0; clear = 1'b0; press = 2'b00;
    resetn = 1'b0;
    #1;
    check({tag, "_rst_p0"}, {p0_tens, p0_ones}, 0);
    check({tag, "_rst_p1"}, {p1_tens, p1_ones}, 0);
    check({tag, "_rst_grant"}, grant, 0);
    check({tag, "_rst_winner"}, winner, 0);
    check({tag, "_rst_game_over"}, game_over, 0);
    model_reset();
    @(posedge clk);
    #1;
    resetn = 1'b1;
  endtask

  typedef struct {
    bit         st;
    logic [1:0] pr;
    int         e0;
    int         e1;
    int         eg;
  } vec_t;

  vec_t tbl[14];

  initial begin
    logic [1:0] rp;
    bit st, cl;

    // From reset: tie, lone p0, then a tie that must favour p1.
    tbl[0]  = '{1, 2'b00, 0, 0, 0};
    tbl[1]  = '{1, 2'b11, 0, 0, 0};
    tbl[2]  = '{1, 2'b00, 0, 0, 1};
    tbl[3]  = '{1, 2'b00, 1, 0, 0};
    tbl[4]  = '{1, 2'b00, 1, 0, 2};
    tbl[5]  = '{1, 2'b00, 1, 1, 0};
    tbl[6]  = '{1, 2'b01, 1, 1, 0};
    tbl[7]  = '{1, 2'b00, 1, 1, 1};
    tbl[8]  = '{1, 2'b00, 2, 1, 0};
    tbl[9]  = '{1, 2'b11, 2, 1, 0};
    tbl[10] = '{1, 2'b00, 2, 1, 2};
    tbl[11] = '{1, 2'b00, 2, 2, 0};
    tbl[12] = '{1, 2'b00, 2, 2, 1};
    tbl[13] = '{1, 2'b00, 3, 2, 0};

    model_reset();
    #2;
    do_reset("t0");
    for (int i = 0; i < 14; i++) begin
      cyc(tbl[i].st, 1'b0, tbl[i].pr);
      check($sformatf("tbl%0d_p0", i), {p0_tens, p0_ones}, to_bcd(tbl[i].e0));
      check($sformatf("tbl%0d_p1", i), {p1_tens, p1_ones}, to_bcd(tbl[i].e1));
      check($sformatf("tbl%0d_grant", i), grant, tbl[i].eg);
    end

    // Held level counts once, then three separate pulses.
    do_reset("held");
    cyc(1'b1, 1'b0, 2'b00);
    for (int i = 0; i < 20; i++) cyc(1'b1, 1'b0, 2'b01);
    cyc(1'b1, 1'b0, 2'b00);
    check("held_once_p0", {p0_tens, p0_ones}, 8'h01);
    for (int i = 0; i < 3; i++) pulse(2'b01);
    check("held_p0_04", {p0_tens, p0_ones}, 8'h04);

    // Drive p1 to the win score; later presses do nothing.
    do_reset("win");
    cyc(1'b1, 1'b0, 2'b00);
    for (int i = 0; i < 19; i++) pulse(2'b10);
    check("win_p1_19", {p1_tens, p1_ones}, 8'h19);
    check("win_not_over", game_over, 0);
    pulse(2'b10);
    check("win_p1_20", {p1_tens, p1_ones}, 8'h20);
    check("win_winner", winner, 2'b10);
    check("win_game_over", game_over, 1);
    pulse(2'b01);
    check("done_p0_frozen", {p0_tens, p0_ones}, 8'h00);
    check("done_no_grant", grant, 0);

    // Clear from DONE, then a press before start is dropped.
    cyc(1'b0, 1'b1, 2'b00);
    check("clr_p1", {p1_tens, p1_ones}, 8'h00);
    check("clr_winner", winner, 0);
    check("clr_game_over", game_over, 0);
    cyc(1'b0, 1'b0, 2'b01);
    cyc(1'b0, 1'b0, 2'b00);
    for (int i = 0; i < 4; i++) cyc(1'b1, 1'b0, 2'b00);
    check("idle_press_dropped", {p0_tens, p0_ones}, 8'h00);

    // Reset asserted mid-INC at 09 must wipe everything at once.
    do_reset("pre_inc");
    cyc(1'b1, 1'b0, 2'b00);
    for (int i = 0; i < 9; i++) pulse(2'b01);
    check("inc_p0_09", {p0_tens, p0_ones}, 8'h09);
    cyc(1'b1, 1'b0, 2'b01);
    cyc(1'b1, 1'b0, 2'b00);
    check("inc_grant_live", grant, 2'b01);
    do_reset("mid_inc");
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, 2'b00);
    check("post_rst_p0", {p0_tens, p0_ones}, 8'h00);

    // Randomized run against the model.
    do_reset("rand");
    rp = 2'b00;
    for (int i = 0; i < 4000; i++) begin
      st = ($urandom_range(0, 3) != 0);
      cl = ($urandom_range(0, 149) == 0);
      for (int b = 0; b < 2; b++)
        if ($urandom_range(0, 2) == 0) rp[b] = ~rp[b];
      cyc(st, cl, rp);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/score_arbiter.md
# score_arbiter

Two-player score controller for the race game: detects press edges from both players, queues them, and arbitrates between the players for one shared two-digit BCD incrementer. It holds each player's score and drives four HEX digits. It stops scoring when a player reaches the win score. It sits between the synchronized KEY inputs and the hex_decoder instances, replacing the single-counter score path.

## Interface
- WIN_TENS, 4'd2, tens digit of win score (BCD, 0-9)
- WIN_ONES, 4'd0, ones digit of win score (BCD, 0-9); win score 00 is illegal
- clk  in  1  system clock (CLOCK_50)
- resetn  in  1  reset, asynchronous, active-low
- start  in  1  level; begins a game from IDLE
- clear  in  1  synchronous restart; return to IDLE, scores zeroed
- press  in  2  per-player button level, active-high, already synchronized to clk
- p0_ones, p0_tens  out  4 each  player 0 score, BCD
- p1_ones, p1_tens  out  4 each  player 1 score, BCD
- grant  out  2  one-hot; high for the single INC cycle of the served player
- winner  out  2  one-hot; winning player, 0 until game ends
- game_over  out  1  high in DONE

## Operation
- Reset values: all scores 0, grant 0, winner 0, game_over 0, pending 0, press_q 0, state IDLE, rr pointer = 1 (player 0 wins first tie).
- Edge detect: press_q <= press every cycle in all states. A rise on player i is press & ~press_q.
- A rise sets pending[i] only in RUN or INC. Rises in IDLE or DONE are dropped.
- A rise while pending[i] is already 1 merges and does not count twice.
- When set and clear of pending[i] happen in the same cycle, set wins.
- FSM states IDLE, RUN, INC, DONE:
  - IDLE -> RUN when start=1.
  - RUN -> INC when any pending is 1. The gnt register is loaded at the same edge and pending[gnt] is cleared.
  - INC -> DONE if the incremented score equals {WIN_TENS,WIN_ONES}; otherwise INC -> RUN.
  - DONE holds until clear.
  - clear=1 in any state -> IDLE with scores, pending and winner zeroed. clear has priority over start.
- Arbitration: if only one player is pending, that player is granted. If both are pending, the player other than rr is granted. rr <= granted player on each grant.
- Increment, applied at the INC exit edge to the granted player only:
  - ones==9 -> ones=0 and tens+1; otherwise ones+1.
  - 99 saturates at 99.
- Win: winner[gnt]=1 and game_over=1 from the DONE entry edge. Any remaining pending for the other player is discarded.

## Timing
- A rise sampled at edge k sets pending at k. The state enters INC and grant asserts at k+1. The score updates at k+2, so latency is 2 edges.
- Throughput: one increment per 2 cycles. With both players pending, service alternates: the second player's score updates 2 cycles after the first.
- grant is exactly one cycle wide and is decoded from the registered gnt in INC.
- resetn low forces all outputs to reset values immediately, mid-INC included. No partial increment survives.

## Structure
- Package score_pkg: state enum (IDLE, RUN, INC, DONE), bcd_t (4-bit digit), NUM_PLAYERS=2.
- Sub-module bcd2_inc: combinational two-digit BCD +1 with saturation at 99. There is one instance, shared through a mux on gnt; this is the arbitrated resource.
- Top holds the FSM, pending, rr pointer and score registers.

## Test plan
- Reset, start, single press on p0 (one cycle high) -> grant=01 for one cycle two edges later; p0 = 01, p1 = 00.
- press=11 rising together from reset -> p0 granted first, p1 two cycles later; each score = 01. The next tie is served p1 first.
- p0 held high for 20 cycles, then three separate press pulses -> p0 = 04, with no repeat from the held level.
- p1 driven to 19, then press -> p1 = 20, winner=10, game_over=1. A later p0 press leaves p0 unchanged.
- Assert resetn low during the INC cycle at score 09 -> all outputs 0 immediately. clear in DONE -> IDLE, scores 00, and a press before start is ignored.
